// File: rtl/riscv_types.sv
// Shared FP writeback types: the buffered result entry and the canonical quiet NaN.
// The FP_WB_CANON_NAN_EN build option uses fp_canon_nan() on every result leaving the arbiter.
package riscv_types;

  localparam int unsigned FP_RD_MAX_W  = 8;
  localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0]            result;
    logic [FP_RD_MAX_W-1:0] rd;
    logic                   fp_reg_write;
  } fp_wb_entry_t;

  // Any NaN (exponent all ones, mantissa non-zero) collapses to the canonical quiet NaN.
  function automatic logic [31:0] fp_canon_nan(input logic [31:0] x);
    if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) return FP_CANON_NAN;
    return x;
  endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// Per-source result buffer. An empty FIFO that is pushed and popped in the same
// cycle forwards the incoming entry straight through without storing it.
module fp_wb_fifo
  import riscv_types::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  fp_wb_entry_t wdata,
  input  logic         pop,
  output fp_wb_entry_t head,
  output logic         avail,
  output logic         drop,
  output logic [CW-1:0] count
);

  fp_wb_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          bypass;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign bypass  = empty & push & pop;
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~bypass & (~full | do_pop);
  assign drop    = push & full & ~pop;
  assign avail   = ~empty | push;
  assign head    = empty ? wdata : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Round-robin writeback arbiter merging FP unit results into one registered port.
// Define FP_WB_CANON_NAN_EN to canonicalise NaN results as they are loaded.
module fp_wb_arbiter
  import riscv_types::*;
#(
  parameter  int unsigned NUM_SRC    = 3,
  parameter  int unsigned DEPTH      = 2,
  parameter  int unsigned addr_width = 5,
  localparam int unsigned SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*32-1:0]         src_result,
  input  logic [NUM_SRC*addr_width-1:0] src_rd,
  input  logic [NUM_SRC-1:0]            src_fp_reg_write,
  input  logic [NUM_SRC-1:0]            clear,
  output logic [NUM_SRC-1:0]            stall_o,
  input  logic                          wb_ready,
  output logic                          wb_valid,
  output logic [31:0]                   wb_result,
  output logic [addr_width-1:0]         wb_rd,
  output logic                          wb_fp_reg_write,
  output logic [SRC_W-1:0]              wb_src,
  output logic                          ovf_o
);

  fp_wb_entry_t       push_data [NUM_SRC];
  fp_wb_entry_t       head      [NUM_SRC];
  logic [CNT_W-1:0]   count     [NUM_SRC];
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] avail;
  logic [NUM_SRC-1:0] drop;
  logic [SRC_W-1:0]   rr;

  logic               out_clear_c;
  logic               load_c;
  logic               gnt_found_c;
  logic [SRC_W-1:0]   gnt_idx_c;
  fp_wb_entry_t       sel_c;
  logic [31:0]        sel_result_c;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign push[g] = src_valid[g] & ~clear[g];
    assign push_data[g].result       = src_result[g*32 +: 32];
    assign push_data[g].rd           = FP_RD_MAX_W'(src_rd[g*addr_width +: addr_width]);
    assign push_data[g].fp_reg_write = src_fp_reg_write[g];
    assign pop[g]     = load_c & gnt_found_c & (gnt_idx_c == SRC_W'(g));
    assign stall_o[g] = (count[g] >= CNT_W'(DEPTH - 1));

    fp_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear[g]),
      .push  (push[g]),
      .wdata (push_data[g]),
      .pop   (pop[g]),
      .head  (head[g]),
      .avail (avail[g]),
      .drop  (drop[g]),
      .count (count[g])
    );
  end

  // A flush of the presented source empties the output register this cycle.
  always_comb begin
    out_clear_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (clear[i] && (wb_src == SRC_W'(i))) out_clear_c = 1'b1;
    end
  end

  assign load_c = ~wb_valid | wb_ready | out_clear_c;

  // Round-robin: first search rr..NUM_SRC-1, then wrap to 0..rr-1.
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!gnt_found_c && avail[i] && !clear[i] && (SRC_W'(i) >= rr)) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = SRC_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!gnt_found_c && avail[i] && !clear[i]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = SRC_W'(i);
      end
    end
  end

  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (gnt_idx_c == SRC_W'(i)) sel_c = head[i];
    end
`ifdef FP_WB_CANON_NAN_EN
    sel_result_c = fp_canon_nan(sel_c.result);
`else
    sel_result_c = sel_c.result;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr              <= '0;
      wb_valid        <= 1'b0;
      wb_result       <= '0;
      wb_rd           <= '0;
      wb_fp_reg_write <= 1'b0;
      wb_src          <= '0;
      ovf_o           <= 1'b0;
    end else begin
      if (|drop) ovf_o <= 1'b1;
      if (load_c) begin
        if (gnt_found_c) begin
          wb_valid        <= 1'b1;
          wb_result       <= sel_result_c;
          wb_rd           <= addr_width'(sel_c.rd);
          wb_fp_reg_write <= sel_c.fp_reg_write;
          wb_src          <= gnt_idx_c;
          rr              <= (gnt_idx_c == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx_c + SRC_W'(1);
        end else begin
          wb_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Scoreboard bench for fp_wb_arbiter: directed pushes queue expected writebacks,
// a negedge monitor retires them on each accepted wb handshake.
module tb_fp_wb_arbiter;

  localparam int unsigned NS = 3;
  localparam int unsigned AW = 5;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        fpw;
    logic [1:0]  src;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [NS-1:0]   src_valid;
  logic [NS*32-1:0] src_result;
  logic [NS*AW-1:0] src_rd;
  logic [NS-1:0]   src_fp_reg_write;
  logic [NS-1:0]   clear;
  logic [NS-1:0]   stall_o;
  logic            wb_ready;
  logic            wb_valid;
  logic [31:0]     wb_result;
  logic [AW-1:0]   wb_rd;
  logic            wb_fp_reg_write;
  logic [1:0]      wb_src;
  logic            ovf_o;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  fp_wb_arbiter #(.NUM_SRC(NS), .DEPTH(2), .addr_width(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .src_valid        (src_valid),
    .src_result       (src_result),
    .src_rd           (src_rd),
    .src_fp_reg_write (src_fp_reg_write),
    .clear            (clear),
    .stall_o          (stall_o),
    .wb_ready         (wb_ready),
    .wb_valid         (wb_valid),
    .wb_result        (wb_result),
    .wb_rd            (wb_rd),
    .wb_fp_reg_write  (wb_fp_reg_write),
    .wb_src           (wb_src),
    .ovf_o            (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input int s, input logic [31:0] r, input logic [4:0] rd, input logic fpw);
    src_valid[s]              = 1'b1;
    src_result[s*32 +: 32]    = r;
    src_rd[s*AW +: AW]        = rd;
    src_fp_reg_write[s]       = fpw;
  endtask

  task automatic expect_wb(input int s, input logic [31:0] r, input logic [4:0] rd, input logic fpw);
    exp_t e;
    e.result = r;
    e.rd     = rd;
    e.fpw    = fpw;
    e.src    = 2'(s);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    src_valid = '0;
    clear     = '0;
  endtask

  // Wait for the scoreboard to empty, then let the last accepted result retire.
  task automatic wait_drain(input int max_cycles);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cycles) begin
      @(negedge clk);
      #1;
      c++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d entries still expected after %0d cycles", exp_q.size(), c);
    end
    tick();
  endtask

  // Monitor: every accepted writeback must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_wb: got src=%0d result=%h rd=%0d, expected nothing",
                 wb_src, wb_result, wb_rd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_result", wb_result, e.result);
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("wb_fp_reg_write", 32'(wb_fp_reg_write), 32'(e.fpw));
        check("wb_src", 32'(wb_src), 32'(e.src));
      end
    end
  end

  initial begin
    logic [31:0] nan_exp;
    rst              = 1'b0;
    src_valid        = '0;
    src_result       = '0;
    src_rd           = '0;
    src_fp_reg_write = '0;
    clear            = '0;
    wb_ready         = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_result", wb_result, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single push, one-cycle latency, then wb_valid drops with nothing queued
    drive(2, 32'h40490FDB, 5'd7, 1'b1);
    expect_wb(2, 32'h40490FDB, 5'd7, 1'b1);
    tick();
    check("single_latency_valid", 32'(wb_valid), 32'd1);
    check("single_src", 32'(wb_src), 32'd2);
    tick();
    check("idle_valid_drop", 32'(wb_valid), 32'd0);

    // Contention: rr is 0 after the grant to source 2, so order is 0,1,2
    drive(0, 32'h3F800000, 5'd1, 1'b1);
    drive(1, 32'h40000000, 5'd2, 1'b0);
    drive(2, 32'hC0400000, 5'd3, 1'b1);
    expect_wb(0, 32'h3F800000, 5'd1, 1'b1);
    expect_wb(1, 32'h40000000, 5'd2, 1'b0);
    expect_wb(2, 32'hC0400000, 5'd3, 1'b1);
    tick();
    check("contend_first_src", 32'(wb_src), 32'd0);
    wait_drain(20);

    // Back-pressure: hold the output, fill source 1, overflow on the third push
    wb_ready = 1'b0;
    drive(0, 32'h11111111, 5'd4, 1'b1);
    expect_wb(0, 32'h11111111, 5'd4, 1'b1);
    tick();
    drive(1, 32'h22222222, 5'd5, 1'b1);
    expect_wb(1, 32'h22222222, 5'd5, 1'b1);
    tick();
    check("bp_stall_after_first", 32'(stall_o[1]), 32'd1);
    check("bp_hold_result", wb_result, 32'h11111111);
    drive(1, 32'h33333333, 5'd6, 1'b0);
    expect_wb(1, 32'h33333333, 5'd6, 1'b0);
    tick();
    check("bp_no_ovf_yet", 32'(ovf_o), 32'd0);
    drive(1, 32'h44444444, 5'd8, 1'b1);
    tick();
    check("bp_ovf", 32'(ovf_o), 32'd1);
    check("bp_hold_valid", 32'(wb_valid), 32'd1);
    check("bp_hold_src", 32'(wb_src), 32'd0);
    wb_ready = 1'b1;
    wait_drain(20);
    check("bp_stall_released", 32'(stall_o[1]), 32'd0);

    // Clear of the presented source with a coincident push
    wb_ready = 1'b0;
    drive(1, 32'h55555555, 5'd9, 1'b1);
    tick();
    check("clr_presented_src", 32'(wb_src), 32'd1);
    check("clr_presented_valid", 32'(wb_valid), 32'd1);
    drive(1, 32'h66666666, 5'd10, 1'b1);
    clear[1] = 1'b1;
    tick();
    check("clr_wb_valid", 32'(wb_valid), 32'd0);
    check("clr_fifo_empty", 32'(stall_o[1]), 32'd0);
    wb_ready = 1'b1;
    repeat (3) tick();
    drive(1, 32'h77777777, 5'd11, 1'b1);
    expect_wb(1, 32'h77777777, 5'd11, 1'b1);
    tick();
    wait_drain(20);

    // NaN handling, plus infinity which is never altered
`ifdef FP_WB_CANON_NAN_EN
    nan_exp = 32'h7FC00000;
`else
    nan_exp = 32'h7F800001;
`endif
    drive(0, 32'h7F800001, 5'd3, 1'b1);
    expect_wb(0, nan_exp, 5'd3, 1'b1);
    tick();
    check("nan_result", wb_result, nan_exp);
    drive(0, 32'h7F800000, 5'd12, 1'b0);
    expect_wb(0, 32'h7F800000, 5'd12, 1'b0);
    tick();
    wait_drain(20);

    // Reset mid-stream with entries queued behind a held output
    wb_ready = 1'b0;
    drive(0, 32'hAAAA0000, 5'd13, 1'b1);
    drive(1, 32'hBBBB0000, 5'd14, 1'b1);
    drive(2, 32'hCCCC0000, 5'd15, 1'b1);
    tick();
    check("mid_valid_before_rst", 32'(wb_valid), 32'd1);
    check("mid_ovf_sticky", 32'(ovf_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(wb_valid), 32'd0);
    check("mid_rst_result", wb_result, 32'd0);
    check("mid_rst_rd", 32'(wb_rd), 32'd0);
    check("mid_rst_fpw", 32'(wb_fp_reg_write), 32'd0);
    check("mid_rst_src", 32'(wb_src), 32'd0);
    check("mid_rst_ovf", 32'(ovf_o), 32'd0);
    check("mid_rst_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    rst      = 1'b1;
    wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", 32'(wb_valid), 32'd0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_wb_arbiter.md
FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, number of FP result sources (0 fadd_sub, 1 fmul, 2 R4 fused unit).
REQ-002 SHALL have parameter DEPTH, default 2, entries per source buffer (power of two, minimum 2).
REQ-003 SHALL have parameter addr_width, default 5, destination register index width.
REQ-004 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port src_valid  input  NUM_SRC  per-source result-valid pulse (the unit's p_out_signal).
REQ-007 SHALL have port src_result  input  NUM_SRC x 32  per-source IEEE-754 single result.
REQ-008 SHALL have port src_rd  input  NUM_SRC x addr_width  per-source destination register.
REQ-009 SHALL have port src_fp_reg_write  input  NUM_SRC  per-source FP register-file write enable.
REQ-010 SHALL have port clear  input  NUM_SRC  per-source flush.
REQ-011 SHALL have port stall_o  output  NUM_SRC  per-source back-pressure, driven to that unit's en (inverted).
REQ-012 SHALL have port wb_ready  input  1  writeback port accepts the presented result this cycle.
REQ-013 SHALL have port wb_valid  output  1  wb_result/wb_rd/wb_fp_reg_write hold a valid result.
REQ-014 SHALL have ports wb_result output 32, wb_rd output addr_width, wb_fp_reg_write output 1, wb_src output clog2(NUM_SRC): the presented result and its source index.
REQ-015 SHALL have port ovf_o  output  1  sticky overflow flag.

Function
REQ-016 SHALL push {result, rd, fp_reg_write} into source i's FIFO when src_valid[i]=1 and clear[i]=0.
REQ-017 SHALL drive stall_o[i]=1 when count_i >= DEPTH-1, a registered-count decode, so one in-flight push is absorbed.
REQ-018 SHALL drop a push into a full FIFO with no pop that cycle and set ovf_o=1 until reset.
REQ-019 SHALL allow push and pop on the same FIFO in one cycle, count unchanged, including when full.
REQ-020 SHALL register the output: load the output register when it is empty or wb_ready=1; wb_valid stays high while wb_ready=0, with all wb_* outputs held stable.
REQ-021 SHALL grant one non-empty FIFO per load by round-robin starting at pointer rr; after a grant to k, rr=(k+1) mod NUM_SRC; rr unchanged when no grant.
REQ-022 SHALL give a result pushed into empty FIFOs with an empty output register wb_valid=1 exactly 1 cycle after src_valid.
REQ-023 SHALL keep per-source order; entries from different sources may reorder.
REQ-024 SHALL on clear[i] empty FIFO i, reset its pointers, ignore a coincident push (clear wins), and invalidate the output register if wb_src=i.
REQ-025 SHALL wrap FIFO read/write pointers modulo DEPTH with a separate count of clog2(DEPTH)+1 bits.
REQ-026 SHALL, when wb_ready=1 and no FIFO is non-empty, drop wb_valid to 0 on the next edge.

Reset
REQ-027 SHALL on rst=0, asynchronously and immediately, clear all FIFOs, rr=0, wb_valid=0, wb_result=0, wb_rd=0, wb_fp_reg_write=0, wb_src=0, ovf_o=0; stall_o=0 follows from the cleared counts.
REQ-028 SHALL discard entries and any presented result when reset asserts mid-operation; no partial writeback after release.

Configuration
REQ-029 SHALL, with FP_WB_CANON_NAN_EN defined, replace any loaded result with exponent 0xFF and mantissa non-zero by 0x7FC00000; without it, pass results bit-exact.

Structure
REQ-030 SHALL place the FIFO entry struct (result, rd, fp_reg_write) and the canonical-NaN constant in riscv_types.
REQ-031 SHALL implement each source buffer as one instance of sub-module fp_wb_fifo, parameterised by DEPTH, generated NUM_SRC times.

Verification
REQ-032 SHALL check single push: src_valid[2]=1, result 0x40490FDB, rd=7 -> next cycle wb_valid=1, wb_result=0x40490FDB, wb_rd=7, wb_src=2.
REQ-033 SHALL check contention: all three valid in one cycle, wb_ready=1, rr=0 -> wb_src sequence 0,1,2 on consecutive cycles.
REQ-034 SHALL check back-pressure: wb_ready=0, two pushes to source 1 -> stall_o[1]=1 after the first; a third push gives ovf_o=1.
REQ-035 SHALL check clear: clear[1] coincident with src_valid[1] while wb_src=1 -> FIFO empty, wb_valid=0 next cycle.
REQ-036 SHALL check NaN canonicalisation: result 0x7F800001 -> 0x7FC00000 with FP_WB_CANON_NAN_EN, 0x7F800001 without.
REQ-037 SHALL check reset mid-stream: rst=0 with 2 entries queued -> all outputs 0 immediately; no wb_valid after release.
